// File: rtl/gfx_sp_file_arbiter.sv
// Shares the vector register file's single read and single write port between two
// operand-fetch requesters (round-robin) and two writeback sources (MEM over ALU).
module gfx_sp_file_arbiter #(
  parameter int RD_LAT = 3,
  parameter int REG_W  = 5,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_a_valid,
  input  logic [REG_W-1:0]  rd_a_reg,
  output logic              rd_a_ready,
  output logic              rd_a_done,
  input  logic              rd_b_valid,
  input  logic [REG_W-1:0]  rd_b_reg,
  output logic              rd_b_ready,
  output logic              rd_b_done,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_mem_valid,
  input  logic [REG_W-1:0]  wb_mem_reg,
  input  logic [DATA_W-1:0] wb_mem_data,
  output logic              wb_mem_ready,
  input  logic              wb_alu_valid,
  input  logic [REG_W-1:0]  wb_alu_reg,
  input  logic [DATA_W-1:0] wb_alu_data,
  output logic              wb_alu_ready,
  output logic [REG_W-1:0]  file_rd_reg,
  input  logic [DATA_W-1:0] file_rd_data,
  output logic              file_wr,
  output logic [REG_W-1:0]  file_wr_reg,
  output logic [DATA_W-1:0] file_wr_data
);

  logic              last_b_q, last_b_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;
  logic              a_elig, b_elig;
  logic              grant_a, grant_b;

  always_comb begin
    wb_mem_ready = rst_n & wb_mem_valid;
    wb_alu_ready = rst_n & wb_alu_valid & ~wb_mem_valid;
    file_wr      = rst_n & (wb_mem_valid | wb_alu_valid);
    file_wr_reg  = wb_mem_valid ? wb_mem_reg  : wb_alu_reg;
    file_wr_data = wb_mem_valid ? wb_mem_data : wb_alu_data;
  end

  // A read of the register being written this cycle waits one cycle so it
  // samples the committed value.
  always_comb begin
    a_elig  = rst_n & rd_a_valid & ~(file_wr & (rd_a_reg == file_wr_reg));
    b_elig  = rst_n & rd_b_valid & ~(file_wr & (rd_b_reg == file_wr_reg));
    grant_a = a_elig & (~b_elig | last_b_q);
    grant_b = b_elig & (~a_elig | ~last_b_q);
    rd_a_ready  = grant_a;
    rd_b_ready  = grant_b;
    file_rd_reg = grant_b ? rd_b_reg : rd_a_reg;
    last_b_d = last_b_q;
    if (grant_b) begin
      last_b_d = 1'b1;
    end else if (grant_a) begin
      last_b_d = 1'b0;
    end
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = grant_a | grant_b;
    tag_id_d[0]  = grant_b;
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_tag_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q[gi] <= 1'b0;
          tag_id_q[gi]  <= 1'b0;
        end else begin
          tag_vld_q[gi] <= tag_vld_q[gi-1];
          tag_id_q[gi]  <= tag_id_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q     <= 1'b1;
      tag_vld_q[0] <= 1'b0;
      tag_id_q[0]  <= 1'b0;
    end else begin
      last_b_q     <= last_b_d;
      tag_vld_q[0] <= tag_vld_d[0];
      tag_id_q[0]  <= tag_id_d[0];
    end
  end

  assign rd_a_done = tag_vld_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
  assign rd_b_done = tag_vld_q[RD_LAT-1] &  tag_id_q[RD_LAT-1];
  assign rd_data   = file_rd_data;

endmodule

// File: tb/tb_gfx_sp_file_arbiter.sv
// Directed bench for gfx_sp_file_arbiter with a register-file model and a
// per-cycle reference model of arbitration, hazards and data return.
module tb_gfx_sp_file_arbiter;
  localparam int RD_LAT = 3;
  localparam int REG_W  = 5;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_a_valid, rd_b_valid;
  logic [REG_W-1:0]  rd_a_reg, rd_b_reg;
  logic              rd_a_ready, rd_a_done, rd_b_ready, rd_b_done;
  logic [DATA_W-1:0] rd_data;
  logic              wb_mem_valid, wb_alu_valid;
  logic [REG_W-1:0]  wb_mem_reg, wb_alu_reg;
  logic [DATA_W-1:0] wb_mem_data, wb_alu_data;
  logic              wb_mem_ready, wb_alu_ready;
  logic [REG_W-1:0]  file_rd_reg;
  logic [DATA_W-1:0] file_rd_data;
  logic              file_wr;
  logic [REG_W-1:0]  file_wr_reg;
  logic [DATA_W-1:0] file_wr_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gfx_sp_file_arbiter #(.RD_LAT(RD_LAT), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_a_valid(rd_a_valid), .rd_a_reg(rd_a_reg), .rd_a_ready(rd_a_ready), .rd_a_done(rd_a_done),
    .rd_b_valid(rd_b_valid), .rd_b_reg(rd_b_reg), .rd_b_ready(rd_b_ready), .rd_b_done(rd_b_done),
    .rd_data(rd_data),
    .wb_mem_valid(wb_mem_valid), .wb_mem_reg(wb_mem_reg), .wb_mem_data(wb_mem_data),
    .wb_mem_ready(wb_mem_ready),
    .wb_alu_valid(wb_alu_valid), .wb_alu_reg(wb_alu_reg), .wb_alu_data(wb_alu_data),
    .wb_alu_ready(wb_alu_ready),
    .file_rd_reg(file_rd_reg), .file_rd_data(file_rd_data),
    .file_wr(file_wr), .file_wr_reg(file_wr_reg), .file_wr_data(file_wr_data)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 5) return {32{4'h1}};
    return {16{b}};
  endfunction

  // Register file: writes commit at the edge ending the wr cycle, reads have RD_LAT stages.
  logic [DATA_W-1:0] fmem [32];
  logic              fwritten [32];
  logic [DATA_W-1:0] fpipe [RD_LAT];
  always @(posedge clk) begin
    fpipe[0] <= fwritten[file_rd_reg] ? fmem[file_rd_reg] : init_val(int'(file_rd_reg));
    for (int i = 1; i < RD_LAT; i++) fpipe[i] <= fpipe[i-1];
    if (file_wr) begin
      fmem[file_wr_reg]     <= file_wr_data;
      fwritten[file_wr_reg] <= 1'b1;
    end
  end
  assign file_rd_data = fpipe[RD_LAT-1];

  task automatic cmp(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: golden register contents plus an ordered list of outstanding reads.
  typedef struct {
    int                due;
    bit                id;
    logic [DATA_W-1:0] data;
  } pend_t;
  pend_t             pend_q[$];
  logic [DATA_W-1:0] gold [32];
  bit                gold_set [32];
  bit                m_last_b = 1'b1;
  int                cyc = 0;
  bit                m_wr, m_ga, m_gb, m_ea, m_eb, m_done_a, m_done_b;
  logic [REG_W-1:0]  m_wreg;
  logic [DATA_W-1:0] m_wdata, m_dexp;
  pend_t             m_p;

  initial begin
    for (int i = 0; i < 32; i++) begin
      fwritten[i] = 1'b0;
      gold_set[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cmp("rst_a_ready", {127'b0, rd_a_ready}, '0);
      cmp("rst_b_ready", {127'b0, rd_b_ready}, '0);
      cmp("rst_mem_ready", {127'b0, wb_mem_ready}, '0);
      cmp("rst_alu_ready", {127'b0, wb_alu_ready}, '0);
      cmp("rst_file_wr", {127'b0, file_wr}, '0);
      cmp("rst_a_done", {127'b0, rd_a_done}, '0);
      cmp("rst_b_done", {127'b0, rd_b_done}, '0);
      pend_q.delete();
      m_last_b = 1'b1;
    end else begin
      m_wr    = wb_mem_valid || wb_alu_valid;
      m_wreg  = wb_mem_valid ? wb_mem_reg : wb_alu_reg;
      m_wdata = wb_mem_valid ? wb_mem_data : wb_alu_data;
      m_ea = rd_a_valid && !(m_wr && rd_a_reg == m_wreg);
      m_eb = rd_b_valid && !(m_wr && rd_b_reg == m_wreg);
      if (m_ea && m_eb) begin
        m_ga = m_last_b;
        m_gb = !m_last_b;
      end else begin
        m_ga = m_ea;
        m_gb = m_eb;
      end
      m_done_a = 0;
      m_done_b = 0;
      m_dexp   = '0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        m_p = pend_q.pop_front();
        m_done_a = !m_p.id;
        m_done_b = m_p.id;
        m_dexp   = m_p.data;
      end
      cmp("file_wr", {127'b0, file_wr}, {127'b0, m_wr});
      cmp("mem_ready", {127'b0, wb_mem_ready}, {127'b0, wb_mem_valid});
      cmp("alu_ready", {127'b0, wb_alu_ready}, {127'b0, wb_alu_valid && !wb_mem_valid});
      if (m_wr) begin
        cmp("file_wr_reg", {123'b0, file_wr_reg}, {123'b0, m_wreg});
        cmp("file_wr_data", file_wr_data, m_wdata);
      end
      cmp("a_ready", {127'b0, rd_a_ready}, {127'b0, m_ga});
      cmp("b_ready", {127'b0, rd_b_ready}, {127'b0, m_gb});
      if (m_ga || m_gb)
        cmp("file_rd_reg", {123'b0, file_rd_reg}, {123'b0, m_gb ? rd_b_reg : rd_a_reg});
      cmp("a_done", {127'b0, rd_a_done}, {127'b0, m_done_a});
      cmp("b_done", {127'b0, rd_b_done}, {127'b0, m_done_b});
      if (m_done_a || m_done_b) cmp("rd_data", rd_data, m_dexp);
      if (m_ga || m_gb) begin
        m_p.due  = cyc + RD_LAT;
        m_p.id   = m_gb;
        m_p.data = gold_set[m_gb ? rd_b_reg : rd_a_reg] ? gold[m_gb ? rd_b_reg : rd_a_reg]
                                                         : init_val(int'(m_gb ? rd_b_reg : rd_a_reg));
        pend_q.push_back(m_p);
        m_last_b = m_gb;
      end
      if (m_wr) begin
        gold[m_wreg]     = m_wdata;
        gold_set[m_wreg] = 1'b1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one(input bit is_b, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] exp);
    if (is_b) begin rd_b_valid = 1; rd_b_reg = r; end
    else begin rd_a_valid = 1; rd_a_reg = r; end
    @(negedge clk);
    cmp("lit_read_ready", {127'b0, is_b ? rd_b_ready : rd_a_ready}, 128'd1);
    step();
    rd_a_valid = 0;
    rd_b_valid = 0;
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      cmp("lit_read_done", {127'b0, is_b ? rd_b_done : rd_a_done}, (k == RD_LAT) ? 128'd1 : 128'd0);
      if (k == RD_LAT) cmp("lit_read_data", rd_data, exp);
      step();
    end
    $display("read %s reg %0d -> %h", is_b ? "B" : "A", r, rd_data);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    rd_a_valid = 0; rd_b_valid = 0; rd_a_reg = '0; rd_b_reg = '0;
    wb_mem_valid = 0; wb_alu_valid = 0; wb_mem_reg = '0; wb_alu_reg = '0;
    wb_mem_data = '0; wb_alu_data = '0;
    repeat (3) step();
    rst_n = 1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmp("lit_idle_ready", {126'b0, rd_a_ready, rd_b_ready}, '0);
      step();
    end
    $display("idle 10 cycles checked");

    rd_a_valid = 1; rd_a_reg = 5'd1;
    rd_b_valid = 1; rd_b_reg = 5'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cmp("lit_alt_a_ready", {127'b0, rd_a_ready}, (k % 2 == 0) ? 128'd1 : 128'd0);
      cmp("lit_alt_b_ready", {127'b0, rd_b_ready}, (k % 2 == 1) ? 128'd1 : 128'd0);
      if (k >= RD_LAT) cmp("lit_alt_a_done", {127'b0, rd_a_done}, ((k - RD_LAT) % 2 == 0) ? 128'd1 : 128'd0);
      $display("alt cycle %0d: a_ready=%0b b_ready=%0b", k, rd_a_ready, rd_b_ready);
      step();
    end
    rd_a_valid = 0; rd_b_valid = 0;
    repeat (4) step();

    read_one(1'b0, 5'd5, {32{4'h1}});

    wb_mem_valid = 1; wb_mem_reg = 5'd7; wb_mem_data = 128'h7777_0000_1234_5678_9ABC_DEF0_0000_0007;
    wb_alu_valid = 1; wb_alu_reg = 5'd8; wb_alu_data = 128'h8888_0000_0000_0000_0000_0000_0000_0008;
    @(negedge clk);
    cmp("lit_wr_mem_ready", {127'b0, wb_mem_ready}, 128'd1);
    cmp("lit_wr_alu_ready0", {127'b0, wb_alu_ready}, 128'd0);
    step();
    wb_mem_valid = 0;
    @(negedge clk);
    cmp("lit_wr_alu_ready1", {127'b0, wb_alu_ready}, 128'd1);
    step();
    wb_alu_valid = 0;
    $display("writes reg7 (MEM) then reg8 (ALU)");
    step();
    read_one(1'b0, 5'd7, 128'h7777_0000_1234_5678_9ABC_DEF0_0000_0007);
    read_one(1'b1, 5'd8, 128'h8888_0000_0000_0000_0000_0000_0000_0008);

    wb_alu_valid = 1; wb_alu_reg = 5'd3; wb_alu_data = 128'hABCD;
    rd_a_valid = 1; rd_a_reg = 5'd3;
    rd_b_valid = 1; rd_b_reg = 5'd4;
    @(negedge clk);
    cmp("lit_haz_a_ready0", {127'b0, rd_a_ready}, 128'd0);
    cmp("lit_haz_b_ready", {127'b0, rd_b_ready}, 128'd1);
    step();
    wb_alu_valid = 0; rd_b_valid = 0;
    @(negedge clk);
    cmp("lit_haz_a_ready1", {127'b0, rd_a_ready}, 128'd1);
    step();
    rd_a_valid = 0;
    @(negedge clk);
    cmp("lit_haz_b_done", {127'b0, rd_b_done}, 128'd0);
    step();
    @(negedge clk);
    cmp("lit_haz_b_done", {127'b0, rd_b_done}, 128'd1);
    cmp("lit_haz_b_data", rd_data, init_val(4));
    step();
    @(negedge clk);
    cmp("lit_haz_a_done", {127'b0, rd_a_done}, 128'd1);
    cmp("lit_haz_a_data", rd_data, 128'hABCD);
    $display("hazard read reg3 -> %h", rd_data);
    step();
    repeat (2) step();

    rd_a_valid = 1; rd_a_reg = 5'd9;
    @(negedge clk);
    cmp("lit_rst_grant", {127'b0, rd_a_ready}, 128'd1);
    step();
    rd_a_valid = 0;
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmp("lit_rst_no_done", {126'b0, rd_a_done, rd_b_done}, '0);
      step();
    end
    $display("reset dropped in-flight read");
    rd_a_valid = 1; rd_a_reg = 5'd1;
    rd_b_valid = 1; rd_b_reg = 5'd2;
    @(negedge clk);
    cmp("lit_tie_a_wins", {126'b0, rd_a_ready, rd_b_ready}, 128'b10);
    step();
    rd_a_valid = 0;
    @(negedge clk);
    cmp("lit_tie_b_next", {127'b0, rd_b_ready}, 128'd1);
    step();
    rd_b_valid = 0;
    repeat (5) step();
    $display("post-reset tie won by A");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
